// File: rtl/timing_check_monitor.sv
// timing_check_monitor
// Watches a data line (d_in) against a monitored flip-flop clock (dut_clk).
// Both are sampled on the local clock. Setup/hold windows are measured in
// clock cycles. The block models the captured flop value (q/qb), flags
// violations with one-cycle pulses, and keeps saturating violation counts.
module timing_check_monitor #(
    parameter int unsigned SETUP_CYC = 4,   // 1..15
    parameter int unsigned HOLD_CYC  = 4,   // 1..15
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             d_in,
    input  logic             dut_clk,
    input  logic             clr_cnt,
    output logic             q,
    output logic             qb,
    output logic             q_valid,
    output logic             setup_viol,
    output logic             hold_viol,
    output logic [CNT_W-1:0] setup_cnt,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [3:0] SETUP_SAT = 4'(SETUP_CYC);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC);

    typedef enum logic {
        IDLE,
        HOLD_WIN
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] hold_left;
    logic [3:0] hold_left_next;
    logic       window_done;

    logic       primed;
    logic       d_prev;
    logic       clk_prev;

    logic [3:0] setup_dist;
    logic [3:0] setup_dist_next;
    logic [3:0] dist_now;

    logic       d_change;
    logic       clk_rise;
    logic       setup_hit;
    logic       hold_hit;

    logic       capture_bad;
    logic       capture_bad_next;

    // Event detection and setup-distance bookkeeping
    always_comb begin
        d_change = primed & (d_in ^ d_prev);
        clk_rise = primed & dut_clk & ~clk_prev;
        // Distance from the most recent data change to this cycle. A change
        // in this cycle counts as distance 0, so an edge in the same cycle
        // is a setup violation.
        dist_now = d_change ? 4'd0 : setup_dist;
        setup_hit = clk_rise & (dist_now < SETUP_SAT);
        // A change that coincides with an edge belongs to the new capture's
        // setup window, never to the previous capture's hold window.
        hold_hit = (state == HOLD_WIN) & d_change & ~clk_rise;
        if (dist_now < SETUP_SAT) begin
            setup_dist_next = dist_now + 4'd1;
        end else begin
            setup_dist_next = SETUP_SAT;
        end
    end

    // Hold-window FSM: next state and hold counter
    always_comb begin
        state_next     = state;
        hold_left_next = hold_left;
        window_done    = 1'b0;
        if (clk_rise) begin
            state_next     = HOLD_WIN;
            hold_left_next = HOLD_LOAD;
        end else begin
            case (state)
                HOLD_WIN: begin
                    if (hold_left <= 4'd1) begin
                        state_next     = IDLE;
                        hold_left_next = 4'd0;
                        window_done    = 1'b1;
                    end else begin
                        hold_left_next = hold_left - 4'd1;
                    end
                end
                default: begin
                    state_next     = IDLE;
                    hold_left_next = hold_left;
                end
            endcase
        end
    end

    // Tracks whether the capture in flight has seen any violation
    always_comb begin
        capture_bad_next = capture_bad;
        if (clk_rise) begin
            capture_bad_next = setup_hit;
        end else if (hold_hit) begin
            capture_bad_next = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_left <= '0;
        end else begin
            state     <= state_next;
            hold_left <= hold_left_next;
        end
    end

    // Previous-value registers; the first cycle after reset only primes them
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            primed     <= 1'b0;
            d_prev     <= 1'b0;
            clk_prev   <= 1'b0;
            setup_dist <= SETUP_SAT;
        end else begin
            primed     <= 1'b1;
            d_prev     <= d_in;
            clk_prev   <= dut_clk;
            setup_dist <= setup_dist_next;
        end
    end

    // Captured value, validity flag and violation pulses
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            q           <= 1'b0;
            q_valid     <= 1'b0;
            capture_bad <= 1'b0;
            setup_viol  <= 1'b0;
            hold_viol   <= 1'b0;
        end else begin
            capture_bad <= capture_bad_next;
            setup_viol  <= setup_hit;
            hold_viol   <= hold_hit;
            if (clk_rise) begin
                q       <= d_in;
                q_valid <= 1'b0;
            end else if (window_done) begin
                // A violation in the final window cycle is not yet in
                // capture_bad, so it is folded in here directly.
                q_valid <= ~(capture_bad | hold_hit);
            end
        end
    end

    // Saturating violation counters; clear wins over increment
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            setup_cnt <= '0;
            hold_cnt  <= '0;
        end else if (clr_cnt) begin
            setup_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            if (setup_hit && (setup_cnt != '1)) begin
                setup_cnt <= setup_cnt + 1'b1;
            end
            if (hold_hit && (hold_cnt != '1)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // Complementary output
    always_comb begin
        qb = ~q;
    end

endmodule

// File: tb/tb_timing_check_monitor.sv
// Testbench for timing_check_monitor (SETUP_CYC=4, HOLD_CYC=4, CNT_W=8).
// Inputs are driven 1 time unit after each rising clock edge; outputs are
// sampled at that same point, so each check sees the registers updated from
// the inputs applied in the preceding cycle.
module tb_timing_check_monitor;

    logic       clock;
    logic       rst_n;
    logic       d_in;
    logic       dut_clk;
    logic       clr_cnt;
    logic       q;
    logic       qb;
    logic       q_valid;
    logic       setup_viol;
    logic       hold_viol;
    logic [7:0] setup_cnt;
    logic [7:0] hold_cnt;

    int n_total = 0;
    int n_pass  = 0;

    timing_check_monitor #(
        .SETUP_CYC (4),
        .HOLD_CYC  (4),
        .CNT_W     (8)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .d_in       (d_in),
        .dut_clk    (dut_clk),
        .clr_cnt    (clr_cnt),
        .q          (q),
        .qb         (qb),
        .q_valid    (q_valid),
        .setup_viol (setup_viol),
        .hold_viol  (hold_viol),
        .setup_cnt  (setup_cnt),
        .hold_cnt   (hold_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic d;
        logic c;
        logic clr;
        int   reps;
        logic q;
        logic qv;
        logic sv;
        logic hv;
        int   sc;
        int   hc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic d, logic c, logic clr, int reps,
                                logic eq, logic eqv, logic esv, logic ehv,
                                int esc, int ehc);
        vec_t v;
        v.d = d; v.c = c; v.clr = clr; v.reps = reps;
        v.q = eq; v.qv = eqv; v.sv = esv; v.hv = ehv; v.sc = esc; v.hc = ehc;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(string name, logic eq, logic eqv, logic esv,
                         logic ehv, int esc, int ehc);
        logic ok;
        ok = (q === eq) && (qb === ~eq) && (q_valid === eqv) &&
             (setup_viol === esv) && (hold_viol === ehv) &&
             (setup_cnt === 8'(esc)) && (hold_cnt === 8'(ehc));
        n_total++;
        if (ok) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got q=%b qb=%b qv=%b sv=%b hv=%b sc=%0d hc=%0d, required q=%b qb=%b qv=%b sv=%b hv=%b sc=%0d hc=%0d",
                     name, q, qb, q_valid, setup_viol, hold_viol, setup_cnt, hold_cnt,
                     eq, ~eq, eqv, esv, ehv, esc, ehc);
        end
    endtask

    initial begin
        logic dv;
        int   pulses;

        // d  c  clr reps  q qv sv hv sc hc
        tbl.push_back(mk(1, 0, 0, 10, 0, 0, 0, 0, 0, 0)); // stable 1 (first tick primes)
        tbl.push_back(mk(1, 1, 0, 1,  1, 0, 0, 0, 0, 0)); // clean edge captures 1
        tbl.push_back(mk(1, 1, 0, 3,  1, 0, 0, 0, 0, 0)); // hold window
        tbl.push_back(mk(1, 0, 0, 1,  1, 1, 0, 0, 0, 0)); // window closes -> valid
        tbl.push_back(mk(1, 0, 0, 2,  1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2,  1, 1, 0, 0, 0, 0)); // change 2 cycles before edge
        tbl.push_back(mk(0, 1, 0, 1,  0, 0, 1, 0, 1, 0)); // setup violation
        tbl.push_back(mk(0, 1, 0, 3,  0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 3,  0, 0, 0, 0, 1, 0)); // valid stays low
        tbl.push_back(mk(1, 0, 0, 4,  0, 0, 0, 0, 1, 0)); // change exactly 4 before edge
        tbl.push_back(mk(1, 1, 0, 1,  1, 0, 0, 0, 1, 0)); // no violation
        tbl.push_back(mk(1, 1, 0, 3,  1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1,  1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1,  1, 0, 0, 0, 1, 0)); // edge
        tbl.push_back(mk(1, 0, 0, 2,  1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1,  1, 0, 0, 1, 1, 1)); // toggle 3 after edge
        tbl.push_back(mk(0, 0, 0, 1,  1, 0, 0, 0, 1, 1)); // window ends invalid
        tbl.push_back(mk(0, 0, 0, 4,  1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1,  0, 0, 0, 0, 1, 1)); // edge captures 0
        tbl.push_back(mk(0, 0, 0, 3,  0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1,  0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1,  0, 1, 0, 0, 1, 1)); // toggle 5 after edge
        tbl.push_back(mk(1, 0, 0, 4,  0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 1,  1, 0, 0, 0, 1, 1)); // edge captures 1
        tbl.push_back(mk(1, 0, 0, 3,  1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 2,  1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1,  0, 0, 1, 0, 2, 1)); // toggle in edge cycle
        tbl.push_back(mk(0, 1, 0, 3,  0, 0, 0, 0, 2, 1));
        tbl.push_back(mk(0, 0, 0, 2,  0, 0, 0, 0, 2, 1));

        rst_n   = 1'b0;
        d_in    = 1'b0;
        dut_clk = 1'b0;
        clr_cnt = 1'b0;
        #2;
        check("reset_state", 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            d_in    = tbl[i].d;
            dut_clk = tbl[i].c;
            clr_cnt = tbl[i].clr;
            for (int r = 0; r < tbl[i].reps; r++) begin
                tick();
                check($sformatf("row%0d_rep%0d", i, r), tbl[i].q, tbl[i].qv,
                      tbl[i].sv, tbl[i].hv, tbl[i].sc, tbl[i].hc);
            end
        end

        // 300 setup violations: toggle on every edge (also inside the
        // previous hold window, which must not count as hold violations).
        dv = d_in;
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            dv = ~dv;
            d_in = dv;
            dut_clk = 1'b1;
            tick();
            if (setup_viol === 1'b1) pulses++;
            dut_clk = 1'b0;
            tick();
            if (setup_viol === 1'b1) pulses++;
        end
        n_total++;
        if (pulses == 300) n_pass++;
        else $display("FAIL sat_pulses: got %0d pulses, required 300", pulses);
        check("sat_counts", dv, 0, 0, 0, 255, 1);

        // Clear together with a violation
        dv = ~dv;
        d_in = dv;
        dut_clk = 1'b1;
        clr_cnt = 1'b1;
        tick();
        check("clr_with_viol", dv, 0, 1, 0, 0, 0);
        clr_cnt = 1'b0;
        dut_clk = 1'b0;
        tick();
        check("clr_after", dv, 0, 0, 0, 0, 0);

        // One more setup violation so the counter is non-zero before reset
        dv = ~dv;
        d_in = dv;
        dut_clk = 1'b1;
        tick();
        check("pre_rst_viol", dv, 0, 1, 0, 1, 0);
        dut_clk = 1'b0;
        repeat (6) tick();
        d_in = 1'b1;
        repeat (5) tick();
        check("pre_rst_idle", dv, 0, 0, 0, 1, 0);

        // Reset 2 cycles after an edge, data toggled during and after reset
        dut_clk = 1'b1;
        tick();
        check("rst_edge", 1, 0, 0, 0, 1, 0);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_async", 0, 0, 0, 0, 0, 0);
        d_in = ~d_in;
        tick();
        check("rst_held", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_in = ~d_in;
            tick();
            check($sformatf("rst_release%0d", i), 0, 0, 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
